// File: rtl/mips_irq_pkg.sv
// Shared constants for the interrupt controller register block.
package mips_irq_pkg;

  // Register map on the data bus
  localparam logic [1:0] IRQ_ADDR_PEND = 2'd0;
  localparam logic [1:0] IRQ_ADDR_MASK = 2'd1;
  localparam logic [1:0] IRQ_ADDR_MODE = 2'd2;
  localparam logic [1:0] IRQ_ADDR_VEC  = 2'd3;

  // Status fields in the VEC register
  localparam int IRQ_VEC_BUSY_BIT = 15;
  localparam int IRQ_VEC_REQ_BIT  = 14;

  // Software-set flag lives in the top data bit; default bus width shown here,
  // the helper gives the position for any configured width.
  localparam int IRQ_DATA_WIDTH = 32;
  localparam int IRQ_SWSET_BIT  = IRQ_DATA_WIDTH - 1;

  function automatic int irq_swset_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-first priority encoder: line 0 wins.
module irq_prio_enc #(
  parameter int N_IRQ = 8,
  parameter int IDX_W = 4
) (
  input  logic [N_IRQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one assigned
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx   = IDX_W'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// N-line interrupt controller: edge/level capture, mask, W1C/software set,
// fixed-priority vectoring with ack / end-of-interrupt handshake.
module irq_controller
  import mips_irq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_IRQ      = 8,
  parameter int IDX_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_IRQ-1:0]      i_irq,
  input  logic                  i_we,
  input  logic [1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ack,
  input  logic                  i_eoi,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_irq,
  output logic [IDX_W-1:0]      o_vec,
  output logic                  o_busy
);

  localparam int SWSET = irq_swset_bit(DATA_WIDTH);

  logic [N_IRQ-1:0] pend, mask, mode, prev;
  logic [N_IRQ-1:0] pend_nxt, rise, w1c, swset, ack_clr, active;
  logic [IDX_W-1:0] vec, sel;
  logic             busy, any, ack_take, wr_pend;

  // Data bits above the line count (except the set flag) carry no meaning
  logic unused_ok;
  assign unused_ok = &{1'b0, i_data};

  assign active = pend & mask;

  irq_prio_enc #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) u_enc (
    .req   (active),
    .idx   (sel),
    .valid (any)
  );

  // An ack only counts when the CPU actually saw a request and nothing is in service
  assign ack_take = i_ack & o_irq & ~busy;
  assign wr_pend  = i_we && (i_addr == IRQ_ADDR_PEND);
  assign rise     = i_irq & ~prev;
  assign w1c      = wr_pend ? i_data[N_IRQ-1:0] : '0;
  assign swset    = (wr_pend && i_data[SWSET]) ? (i_data[N_IRQ-1:0] & mode) : '0;
  assign ack_clr  = ack_take ? (mode & (N_IRQ'(1) << sel)) : '0;

  // Edge lines: clears first, sets override. Level lines track the input.
  always_comb begin
    pend_nxt = (pend & ~(w1c | ack_clr)) | rise | swset;
    pend_nxt = (mode & pend_nxt) | (~mode & i_irq);
  end

  // Register state, handshake and the request line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      prev  <= '0;
      vec   <= '0;
      busy  <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      prev  <= i_irq;
      pend  <= pend_nxt;
      o_irq <= any & ~busy & ~i_ack;
      if (i_we && i_addr == IRQ_ADDR_MASK) mask <= i_data[N_IRQ-1:0];
      if (i_we && i_addr == IRQ_ADDR_MODE) mode <= i_data[N_IRQ-1:0];
      // EOI wins; ack_take already excludes the busy case
      if (i_eoi && busy) begin
        busy <= 1'b0;
      end else if (ack_take) begin
        busy <= 1'b1;
        vec  <= sel;
      end
    end
  end

  // Combinational register read, upper bits zero
  always_comb begin
    o_data = '0;
    case (i_addr)
      IRQ_ADDR_PEND: o_data[N_IRQ-1:0] = pend;
      IRQ_ADDR_MASK: o_data[N_IRQ-1:0] = mask;
      IRQ_ADDR_MODE: o_data[N_IRQ-1:0] = mode;
      default: begin
        o_data[IDX_W-1:0]        = vec;
        o_data[IRQ_VEC_REQ_BIT]  = o_irq;
        o_data[IRQ_VEC_BUSY_BIT] = busy;
      end
    endcase
  end

  assign o_vec  = vec;
  assign o_busy = busy;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int IW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_we, i_ack, i_eoi;
  logic [N-1:0]  i_irq;
  logic [1:0]    i_addr;
  logic [DW-1:0] i_data, o_data;
  logic          o_irq, o_busy;
  logic [IW-1:0] o_vec;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(.DATA_WIDTH(DW), .N_IRQ(N), .IDX_W(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_irq(i_irq), .i_we(i_we), .i_addr(i_addr),
    .i_data(i_data), .i_ack(i_ack), .i_eoi(i_eoi), .o_data(o_data),
    .o_irq(o_irq), .o_vec(o_vec), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    i_addr = a;
    #1;
    d = o_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    i_we = 1'b1; i_addr = a; i_data = d;
    tick();
    i_we = 1'b0; i_data = '0;
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    i_eoi = 1'b1; tick(); i_eoi = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    i_rst = 1'b0; i_we = 1'b0; i_ack = 1'b0; i_eoi = 1'b0;
    i_addr = '0; i_data = '0; i_irq = 8'hFF;
    tick();

    // Reset with all lines high
    do_reset();
    chk("rst_irq", o_irq, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_vec", o_vec, 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 0);
    end
    tick();
    rd(0, d); chk("lvl_after_rst_pend", d, 32'hFF);
    tick();
    chk("masked_no_irq", o_irq, 0);
    rd(0, d); chk("masked_stays_pend", d, 32'hFF);

    // Edge latch and W1C
    i_irq = 8'h00; tick();
    wr(2, 32'h0F);
    wr(1, 32'h0F);
    rd(0, d); chk("edge_idle_pend", d, 0);
    i_irq = 8'h04; tick(); i_irq = 8'h00;
    rd(0, d); chk("edge_pend", d, 32'h04);
    chk("edge_irq_lag", o_irq, 0);
    tick();
    chk("edge_irq", o_irq, 1);
    wr(0, 32'h04);
    rd(0, d); chk("w1c_pend", d, 0);
    tick();
    chk("w1c_irq", o_irq, 0);
    wr(3, 32'hFFFF_FFFF);
    rd(3, d); chk("vec_ro", d, 0);

    // Priority and ack
    do_reset();
    i_irq = 8'h00; tick();
    wr(2, 32'hFF);
    wr(1, 32'hFF);
    i_irq = 8'h22; tick(); i_irq = 8'h00;
    tick();
    chk("prio_irq", o_irq, 1);
    pulse_ack();
    chk("prio_vec1", o_vec, 1);
    chk("prio_busy", o_busy, 1);
    rd(0, d); chk("prio_pend", d, 32'h20);
    chk("prio_irq_low", o_irq, 0);
    tick();
    chk("busy_no_nest", o_irq, 0);
    pulse_eoi();
    chk("eoi_busy", o_busy, 0);
    tick();
    chk("eoi_irq", o_irq, 1);
    pulse_ack();
    chk("prio_vec5", o_vec, 5);
    rd(3, d); chk("vec_reg", d, 32'h8005);

    // Level line
    do_reset();
    i_irq = 8'h01;
    wr(1, 32'h01);
    tick();
    chk("lvl_irq", o_irq, 1);
    pulse_ack();
    chk("lvl_vec", o_vec, 0);
    chk("lvl_busy", o_busy, 1);
    rd(0, d); chk("lvl_pend_kept", d, 32'h01);
    pulse_eoi();
    tick();
    chk("lvl_reassert", o_irq, 1);
    i_irq = 8'h00; tick();
    rd(0, d); chk("lvl_drop", d, 0);

    // Simultaneous set and clear
    do_reset();
    i_irq = 8'h00; tick();
    wr(2, 32'h08);
    i_irq = 8'h08;
    wr(0, 32'h08);
    rd(0, d); chk("set_wins", d, 32'h08);
    wr(0, 32'h08);
    rd(0, d); chk("w1c_no_edge", d, 0);

    // Software set and illegal handshakes
    do_reset();
    i_irq = 8'h00; tick();
    wr(2, 32'h40);
    wr(1, 32'h40);
    pulse_ack();
    rd(3, d); chk("ack_no_req", d, 0);
    pulse_eoi();
    rd(3, d); chk("eoi_not_busy", d, 0);
    wr(0, 32'h8000_0040);
    rd(0, d); chk("swset_pend", d, 32'h40);
    tick();
    chk("swset_irq", o_irq, 1);
    rd(3, d); chk("vec_req_bit", d, 32'h4000);
    pulse_ack();
    chk("sw_vec", o_vec, 6);
    rd(0, d); chk("sw_ack_clr", d, 0);
    i_ack = 1'b1; i_eoi = 1'b1; tick(); i_ack = 1'b0; i_eoi = 1'b0;
    chk("ackeoi_busy", o_busy, 0);
    chk("ackeoi_vec", o_vec, 6);
    wr(0, 32'h8000_0080);
    rd(0, d); chk("swset_level_ign", d, 0);

    // Reset mid-handshake
    i_irq = 8'h40; tick(); i_irq = 8'h00;
    tick();
    pulse_ack();
    chk("mid_busy", o_busy, 1);
    do_reset();
    rd(3, d); chk("mid_rst", d, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
